// File: rtl/simple_dma_controller_pkg.sv
// rtl/simple_dma_controller_pkg.sv - shared state encoding and constants for the DMA responder
package simple_dma_controller_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_DEV = 3'd1,
    MEM_REQ  = 3'd2,
    RD_DATA  = 3'd3,
    ACK      = 3'd4,
    GAP      = 3'd5,
    DONE     = 3'd6
  } dma_state_t;

  // Byte address step between consecutive 16-bit words.
  localparam logic [15:0] ADDR_INC = 16'd2;

  localparam logic DIR_RD = 1'b1;
  localparam logic DIR_WR = 1'b0;

endpackage

// File: rtl/simple_dma_controller.sv
// rtl/simple_dma_controller.sv - memory-side responder moving words between memory and a DMA device
module simple_dma_controller
  import simple_dma_controller_pkg::*;
#(
  parameter logic MEM_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_rqst,
  input  logic        dma_rd_wr,
  input  logic [15:0] dma_start_address,
  input  logic [15:0] dma_num_words,
  input  logic        dev_ack,
  input  logic [15:0] dev_out,
  output logic        dma_ack,
  output logic        dma_end_flag,
  output logic [15:0] dev_in,
  output logic        dma_error,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_en,
  output logic [1:0]  mem_we,
  output logic        mem_priority,
  input  logic [15:0] mem_dout,
  input  logic        mem_ready,
  input  logic        mem_resp
);

  dma_state_t  state;
  dma_state_t  state_nxt;
  logic [15:0] addr;
  logic [15:0] count;
  logic        dir;
  logic        dev_rdy;
  logic        mem_write;

  // A device ack seen this cycle counts immediately, so a level ack does not
  // cost an extra WAIT_DEV cycle per word.
  logic        dev_ready_now;
  assign dev_ready_now = dev_rdy | dev_ack;

  assign mem_write    = (state == MEM_REQ) && (dir == DIR_WR);
  assign mem_en       = (state == MEM_REQ);
  assign mem_we       = mem_write ? 2'b11 : 2'b00;
  assign mem_din      = mem_write ? dev_out : 16'h0000;
  assign mem_addr     = addr[15:1];
  assign mem_priority = MEM_PRIORITY;
  assign dma_ack      = (state == ACK);
  assign dma_end_flag = (state == DONE);

  // Next-state selection; a dropped request only aborts once no memory access is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dma_rqst) begin
          state_nxt = (dma_num_words == 16'd0) ? DONE : WAIT_DEV;
        end
      end
      WAIT_DEV: begin
        if (!dma_rqst) begin
          state_nxt = IDLE;
        end else if (dev_ready_now) begin
          state_nxt = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_ready) begin
          if (dir == DIR_RD) begin
            state_nxt = RD_DATA;
          end else if (!dma_rqst) begin
            state_nxt = IDLE;
          end else if (mem_resp) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ACK;
          end
        end
      end
      RD_DATA: begin
        if (!dma_rqst) begin
          state_nxt = IDLE;
        end else if (mem_resp) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        state_nxt = GAP;
      end
      GAP: begin
        if (!dma_rqst) begin
          state_nxt = IDLE;
        end else if (count == 16'd0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT_DEV;
        end
      end
      DONE: begin
        if (!dma_rqst) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, transfer bookkeeping, read data capture and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= 16'h0000;
      count     <= 16'h0000;
      dir       <= DIR_WR;
      dev_rdy   <= 1'b0;
      dev_in    <= 16'h0000;
      dma_error <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ACK) begin
        dev_rdy <= 1'b0;
      end else if (dev_ack && (state != GAP)) begin
        dev_rdy <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (dma_rqst) begin
            addr      <= {dma_start_address[15:1], 1'b0};
            count     <= dma_num_words;
            dir       <= dma_rd_wr;
            dma_error <= 1'b0;
          end
        end
        MEM_REQ: begin
          if (mem_ready && (dir == DIR_WR) && mem_resp) begin
            dma_error <= 1'b1;
          end
        end
        RD_DATA: begin
          if (mem_resp) begin
            dma_error <= 1'b1;
          end else begin
            dev_in <= mem_dout;
          end
        end
        ACK: begin
          addr  <= addr + ADDR_INC;
          count <= count - 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_dma_controller.sv
// tb/tb_simple_dma_controller.sv - directed self-checking bench for simple_dma_controller
module tb_simple_dma_controller;

  logic        clk;
  logic        reset;
  logic        dma_rqst;
  logic        dma_rd_wr;
  logic [15:0] dma_start_address;
  logic [15:0] dma_num_words;
  logic        dev_ack;
  logic [15:0] dev_out;
  logic        dma_ack;
  logic        dma_end_flag;
  logic [15:0] dev_in;
  logic        dma_error;
  logic [14:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_en;
  logic [1:0]  mem_we;
  logic        mem_priority;
  logic [15:0] mem_dout = 16'h0000;
  logic        mem_ready;
  logic        mem_resp;

  simple_dma_controller dut (
    .clk               (clk),
    .reset             (reset),
    .dma_rqst          (dma_rqst),
    .dma_rd_wr         (dma_rd_wr),
    .dma_start_address (dma_start_address),
    .dma_num_words     (dma_num_words),
    .dev_ack           (dev_ack),
    .dev_out           (dev_out),
    .dma_ack           (dma_ack),
    .dma_end_flag      (dma_end_flag),
    .dev_in            (dev_in),
    .dma_error         (dma_error),
    .mem_addr          (mem_addr),
    .mem_din           (mem_din),
    .mem_en            (mem_en),
    .mem_we            (mem_we),
    .mem_priority      (mem_priority),
    .mem_dout          (mem_dout),
    .mem_ready         (mem_ready),
    .mem_resp          (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read contents are preloaded by the stimulus; writes land in a separate array.
  logic [15:0] rmem [0:32767];
  logic [15:0] wmem [0:32767];
  logic        err_en;
  logic [14:0] err_addr;
  logic        resp_q = 1'b0;

  assign mem_resp = resp_q;

  always @(posedge clk) begin
    if (mem_en && mem_ready) begin
      if (mem_we == 2'b11) wmem[mem_addr] <= mem_din;
      else                 mem_dout <= rmem[mem_addr];
      resp_q <= err_en && (mem_addr == err_addr);
    end else begin
      resp_q <= 1'b0;
    end
  end

  logic [15:0] ack_q[$];
  logic [14:0] acc_addr_q[$];
  logic [15:0] acc_din_q[$];
  logic [1:0]  acc_we_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (dma_ack) ack_q.push_back(dev_in);
      if (mem_en && mem_ready) begin
        acc_addr_q.push_back(mem_addr);
        acc_din_q.push_back(mem_din);
        acc_we_q.push_back(mem_we);
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_end(input int budget, output int n);
    n = 0;
    while (!dma_end_flag && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic start_op(input logic rd, input logic [15:0] a, input logic [15:0] nw);
    dma_rd_wr         = rd;
    dma_start_address = a;
    dma_num_words     = nw;
    dma_rqst          = 1'b1;
  endtask

  int a0, b0, n;

  initial begin
    reset = 1'b1;
    dma_rqst = 1'b0; dma_rd_wr = 1'b0; dma_start_address = 16'h0; dma_num_words = 16'h0;
    dev_ack = 1'b0; dev_out = 16'h0; mem_ready = 1'b1; err_en = 1'b0; err_addr = 15'h0;
    rmem[15'h100] = 16'h1111; rmem[15'h101] = 16'h2222; rmem[15'h102] = 16'h3333;
    rmem[15'h200] = 16'h4444; rmem[15'h201] = 16'h5555;
    rmem[15'h7FFF] = 16'hBEEF; rmem[15'h0000] = 16'hCAFE;
    rmem[15'h050] = 16'h1234; rmem[15'h051] = 16'h9999;
    step(2);
    chk("rst_outputs", {dma_ack, dma_end_flag, dev_in, dma_error, mem_addr, mem_din, mem_en, mem_we}, 32'h0);
    chk("rst_prio", mem_priority, 1'b0);
    reset = 1'b0;
    step(1);

    // Read 3 words from 0x0200 with dev_ack held high.
    a0 = ack_q.size(); b0 = acc_addr_q.size();
    dev_ack = 1'b1;
    start_op(1'b1, 16'h0200, 16'd3);
    step(1);
    chk("t1_no_en_wait", mem_en, 1'b0);
    step(1);
    chk("t1_first_en", mem_en, 1'b1);
    chk("t1_first_addr", mem_addr, 15'h100);
    chk("t1_first_we", mem_we, 2'b00);
    wait_end(40, n);
    chk("t1_end_latency", n, 14);
    chk("t1_ack_cnt", ack_q.size() - a0, 3);
    chk("t1_acc_cnt", acc_addr_q.size() - b0, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_addr%0d", i), acc_addr_q[b0 + i], 15'h100 + 15'(i));
      chk($sformatf("t1_data%0d", i), ack_q[a0 + i], 16'h1111 * 16'(i + 1));
    end
    chk("t1_no_err", dma_error, 1'b0);
    dma_rqst = 1'b0;
    step(1);
    chk("t1_end_clear", dma_end_flag, 1'b0);

    // Write 2 words to 0x0300, one dev_ack pulse per word.
    a0 = ack_q.size(); b0 = acc_addr_q.size();
    dev_out = 16'hAAAA;
    start_op(1'b0, 16'h0300, 16'd2);
    dev_ack = 1'b1;
    step(1);
    dev_ack = 1'b0;
    step(6);
    chk("t2_one_acc", acc_addr_q.size() - b0, 1);
    chk("t2_one_ack", ack_q.size() - a0, 1);
    chk("t2_waiting_no_en", mem_en, 1'b0);
    chk("t2_din0", acc_din_q[b0], 16'hAAAA);
    chk("t2_we0", acc_we_q[b0], 2'b11);
    dev_out = 16'h5555;
    dev_ack = 1'b1;
    step(1);
    dev_ack = 1'b0;
    wait_end(20, n);
    chk("t2_end", dma_end_flag, 1'b1);
    chk("t2_two_acc", acc_addr_q.size() - b0, 2);
    chk("t2_addr1", acc_addr_q[b0 + 1], 15'h181);
    chk("t2_din1", acc_din_q[b0 + 1], 16'h5555);
    chk("t2_mem0", wmem[15'h180], 16'hAAAA);
    chk("t2_mem1", wmem[15'h181], 16'h5555);
    chk("t2_two_ack", ack_q.size() - a0, 2);
    dma_rqst = 1'b0;
    step(1);

    // Zero-length request.
    b0 = acc_addr_q.size();
    start_op(1'b1, 16'h1234, 16'd0);
    step(1);
    chk("t3_end_1cyc", dma_end_flag, 1'b1);
    chk("t3_no_en", mem_en, 1'b0);
    step(3);
    chk("t3_no_acc", acc_addr_q.size() - b0, 0);
    chk("t3_end_held", dma_end_flag, 1'b1);
    dma_rqst = 1'b0;
    step(1);
    chk("t3_end_clear", dma_end_flag, 1'b0);

    // Read with a 3-cycle memory stall and dev_ack dropping after the first word.
    a0 = ack_q.size(); b0 = acc_addr_q.size();
    mem_ready = 1'b0;
    dev_ack = 1'b1;
    start_op(1'b1, 16'h0400, 16'd2);
    step(2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_stall_en%0d", i), mem_en, 1'b1);
      chk($sformatf("t4_stall_addr%0d", i), mem_addr, 15'h200);
      chk($sformatf("t4_stall_we%0d", i), mem_we, 2'b00);
      if (i < 2) step(1);
    end
    mem_ready = 1'b1;
    dev_ack = 1'b0;
    step(6);
    chk("t4_one_ack", ack_q.size() - a0, 1);
    chk("t4_data0", ack_q[a0], 16'h4444);
    chk("t4_held_dev_in", dev_in, 16'h4444);
    chk("t4_waiting", {mem_en, dma_end_flag}, 2'b00);
    dev_ack = 1'b1;
    wait_end(30, n);
    chk("t4_end", dma_end_flag, 1'b1);
    chk("t4_two_ack", ack_q.size() - a0, 2);
    chk("t4_data1", ack_q[a0 + 1], 16'h5555);
    dma_rqst = 1'b0;
    step(1);

    // Address wrap from 0xFFFE.
    a0 = ack_q.size(); b0 = acc_addr_q.size();
    start_op(1'b1, 16'hFFFE, 16'd2);
    wait_end(40, n);
    chk("t5_end", dma_end_flag, 1'b1);
    chk("t5_addr0", acc_addr_q[b0], 15'h7FFF);
    chk("t5_addr1", acc_addr_q[b0 + 1], 15'h0000);
    chk("t5_data0", ack_q[a0], 16'hBEEF);
    chk("t5_data1", ack_q[a0 + 1], 16'hCAFE);
    dma_rqst = 1'b0;
    step(1);

    // Memory error on word 2 of 4.
    a0 = ack_q.size(); b0 = acc_addr_q.size();
    err_en = 1'b1; err_addr = 15'h051;
    start_op(1'b1, 16'h00A0, 16'd4);
    wait_end(40, n);
    chk("t6_end", dma_end_flag, 1'b1);
    chk("t6_err", dma_error, 1'b1);
    chk("t6_one_ack", ack_q.size() - a0, 1);
    chk("t6_two_acc", acc_addr_q.size() - b0, 2);
    err_en = 1'b0;
    dma_rqst = 1'b0;
    step(1);
    chk("t6_err_level", dma_error, 1'b1);
    chk("t6_end_clear", dma_end_flag, 1'b0);

    // Reset while stalled in MEM_REQ.
    mem_ready = 1'b0;
    start_op(1'b1, 16'h00A0, 16'd4);
    step(1);
    chk("t7_err_cleared", dma_error, 1'b0);
    step(1);
    chk("t7_in_memreq", mem_en, 1'b1);
    chk("t7_dev_in_pre", dev_in, 16'h1234);
    reset = 1'b1;
    #1;
    chk("t7_async_rst", {dma_ack, dma_end_flag, dev_in, dma_error, mem_addr, mem_din, mem_en, mem_we}, 32'h0);
    dma_rqst = 1'b0;
    step(1);
    reset = 1'b0;
    step(1);
    chk("t7_idle_after", {mem_en, dma_end_flag}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
